// File: rtl/rr_index_arbiter.sv
// -----------------------------------------------------------------------------
// rr_index_arbiter
//
// Round-robin arbiter for eight level-sensitive request lines. The winner is
// presented as a registered 3-bit index plus a valid flag, ready to drive a
// 3-to-8 decoder whose one-hot output is gated by `valid`. Every grant is
// followed by at least one idle cycle, so decoded enables never overlap.
//
// Parameters:
//   MAX_HOLD  maximum grant tenure in clock cycles (legal range 2..255)
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   8  request lines, req[i] belongs to requester i
//   done     in   1  grantee release pulse, only looked at while valid=1
//   idx      out  3  index of the current or most recent grantee
//   valid    out  1  idx is an active grant
//   timeout  out  1  one-cycle pulse when a grant is revoked by tenure expiry
// -----------------------------------------------------------------------------
module rr_index_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] idx,
  output logic       valid,
  output logic       timeout
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  logic          state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          timeout_q, timeout_d;

  logic [15:0]   req_dbl;
  logic [7:0]    req_rot;
  logic [2:0]    win_off;
  logic [2:0]    winner;

  logic          req_held;
  logic          expired;
  logic          release_grant;

  // Rotate the request vector so the pointer position lands at bit 0, then
  // pick the lowest set bit. The downward loop lets the lowest index win.
  // Adding the offset back to the pointer wraps naturally in 3 bits.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[{1'b0, ptr_q} +: 8];
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 3'(i);
      end
    end
    winner = ptr_q + win_off;
  end

  // Release happens on done, on the grantee dropping its request, or when the
  // tenure counter reaches its last value. timeout is reserved for the case
  // where expiry is the only reason.
  always_comb begin
    req_held      = req[idx_q];
    expired       = (cnt_q == CNT_LAST);
    release_grant = done | ~req_held | expired;

    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;

    if (state_q == ST_IDLE) begin
      if (req != 8'd0) begin
        idx_d   = winner;
        cnt_d   = '0;
        state_d = ST_GRANT;
      end
    end else begin
      if (release_grant) begin
        ptr_d     = idx_q + 3'd1;
        state_d   = ST_IDLE;
        timeout_d = expired & ~done & req_held;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  // valid is exactly the GRANT state flop, so it stays a registered output.
  assign idx     = idx_q;
  assign valid   = (state_q == ST_GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
module tb_rr_index_arbiter;

   logic       clock;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [2:0] idx;
   logic       valid;
   logic       timeout;

   int numCompared;
   int numMismatched;

   typedef struct {
      logic [7:0] req;
      logic       done;
      logic [2:0] expIdx;
      logic       expValid;
      logic       expTimeout;
      string      name;
   } vector_t;

   vector_t vectors[$];

   rr_index_arbiter #(.MAX_HOLD(16)) dut (
      .clk    (clock),
      .rst_n  (rst_n),
      .req    (req),
      .done   (done),
      .idx    (idx),
      .valid  (valid),
      .timeout(timeout)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive inputs, advance one rising edge, and settle 2ns past it.
   task automatic applyStimulus(input logic [7:0] reqIn, input logic doneIn);
      req  = reqIn;
      done = doneIn;
      @(posedge clock);
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [2:0] expIdx,
                              input logic expValid, input logic expTimeout);
      numCompared++;
      if (idx !== expIdx || valid !== expValid || timeout !== expTimeout) begin
         numMismatched++;
         $display("[TB] FAIL %s: got idx=%0d valid=%b timeout=%b, expected idx=%0d valid=%b timeout=%b",
                  name, idx, valid, timeout, expIdx, expValid, expTimeout);
      end
   endtask

   task automatic addVector(input logic [7:0] r, input logic d, input logic [2:0] ei,
                            input logic ev, input logic et, input string n);
      vector_t v;
      v.req = r; v.done = d; v.expIdx = ei; v.expValid = ev; v.expTimeout = et; v.name = n;
      vectors.push_back(v);
   endtask

   initial begin
      numCompared   = 0;
      numMismatched = 0;

      // Round robin straight out of reset: grant on even steps, release on odd.
      for (int i = 0; i < 20; i++) begin
         addVector(8'hFF, 1'b1, 3'((i / 2) % 8), (i % 2 == 0), 1'b0,
                   $sformatf("rr_step%0d", i));
      end
      // Pointer is now 2.
      addVector(8'h20, 1'b0, 3'd5, 1'b1, 1'b0, "single_grant5");
      addVector(8'h20, 1'b1, 3'd5, 1'b0, 1'b0, "single_done5");
      addVector(8'h00, 1'b0, 3'd5, 1'b0, 1'b0, "idle_hold_idx");
      addVector(8'h00, 1'b1, 3'd5, 1'b0, 1'b0, "done_while_idle");
      // Pointer is now 6.
      addVector(8'h80, 1'b0, 3'd7, 1'b1, 1'b0, "grant7");
      addVector(8'h80, 1'b1, 3'd7, 1'b0, 1'b0, "release7");
      addVector(8'h88, 1'b0, 3'd3, 1'b1, 1'b0, "wrap_88_to3");
      addVector(8'h88, 1'b1, 3'd3, 1'b0, 1'b0, "release3");
      addVector(8'h40, 1'b0, 3'd6, 1'b1, 1'b0, "grant6");
      addVector(8'h40, 1'b1, 3'd6, 1'b0, 1'b0, "release6");
      addVector(8'h41, 1'b0, 3'd0, 1'b1, 1'b0, "wrap_41_to0");
      addVector(8'h41, 1'b1, 3'd0, 1'b0, 1'b0, "release0");
      // Pointer is now 1: grant 2, extra request arrives mid-grant, then drop.
      addVector(8'h04, 1'b0, 3'd2, 1'b1, 1'b0, "grant2_c1");
      addVector(8'h04, 1'b0, 3'd2, 1'b1, 1'b0, "grant2_c2");
      addVector(8'h0C, 1'b0, 3'd2, 1'b1, 1'b0, "grant2_c3_newreq");
      addVector(8'h08, 1'b0, 3'd2, 1'b0, 1'b0, "drop_req2");

      // Reset held with all requests active while the clock runs.
      req   = 8'hFF;
      done  = 1'b0;
      rst_n = 1'b0;
      #2;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("reset_hold%0d", i), 3'd0, 1'b0, 1'b0);
         @(posedge clock);
         #2;
      end
      // Release between edges; the first grant comes one edge later.
      rst_n = 1'b1;

      for (int i = 0; i < vectors.size(); i++) begin
         applyStimulus(vectors[i].req, vectors[i].done);
         checkOutput(vectors[i].name, vectors[i].expIdx, vectors[i].expValid,
                     vectors[i].expTimeout);
      end

      // Pointer is 3, IDLE. Timeout: valid high for exactly 16 cycles.
      applyStimulus(8'h08, 1'b0);
      checkOutput("to_grant_c1", 3'd3, 1'b1, 1'b0);
      for (int c = 2; c <= 16; c++) begin
         applyStimulus(8'h08, 1'b0);
         checkOutput($sformatf("to_hold_c%0d", c), 3'd3, 1'b1, 1'b0);
      end
      applyStimulus(8'h08, 1'b0);
      checkOutput("to_expire", 3'd3, 1'b0, 1'b1);
      applyStimulus(8'h08, 1'b0);
      checkOutput("to_regrant", 3'd3, 1'b1, 1'b0);

      // Same tenure but done arrives together with expiry: no timeout.
      for (int c = 2; c <= 16; c++) begin
         applyStimulus(8'h08, 1'b0);
         if (c == 16) checkOutput("done_exp_c16", 3'd3, 1'b1, 1'b0);
      end
      applyStimulus(8'h08, 1'b1);
      checkOutput("done_with_expiry", 3'd3, 1'b0, 1'b0);

      // Mid-grant asynchronous reset takes effect before any clock edge.
      applyStimulus(8'h08, 1'b0);
      checkOutput("pre_reset_grant", 3'd3, 1'b1, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_now", 3'd0, 1'b0, 1'b0);
      @(posedge clock);
      #2;
      checkOutput("async_reset_held", 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      applyStimulus(8'h08, 1'b0);
      checkOutput("post_reset_grant", 3'd3, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
